// File: rtl/seg7_scan_display.sv
// Multiplexed 4-digit common-anode seven-segment driver.
// The CPU word is double-buffered: load writes a pending register, and the
// displayed word is only replaced when the scan wraps from digit 3 to digit 0,
// so a frame never mixes nibbles from two different words.
module seg7_scan_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  digit,
    output logic [7:0]  segment,
    output logic [15:0] shown,
    output logic        frame
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_pending;
    logic             r_pend_v;
    logic [15:0]      r_shown;
    logic [3:0]       r_digit;
    logic [7:0]       r_segment;
    logic             r_frame;

    logic             w_cnt_last;
    logic             w_wrap;
    logic [3:0]       w_nib;
    logic             w_z3;
    logic             w_z2;
    logic             w_z1;
    logic [3:0]       w_blank;
    logic [3:0]       w_digit_nxt;
    logic [7:0]       w_segment_nxt;

    assign w_cnt_last = (r_cnt == CNT_MAX);
    // Last cycle of the digit-3 slot: the edge that moves idx from 3 to 0.
    assign w_wrap     = w_cnt_last && (r_idx == 2'd3);

    assign w_nib = r_shown[{r_idx, 2'b00} +: 4];

    // A digit is a leading zero only if it and every higher nibble are zero.
    assign w_z3 = (r_shown[15:12] == 4'h0);
    assign w_z2 = (r_shown[11:8] == 4'h0);
    assign w_z1 = (r_shown[7:4] == 4'h0);

    assign w_blank[3] = blank_lz && w_z3;
    assign w_blank[2] = blank_lz && w_z3 && w_z2;
    assign w_blank[1] = blank_lz && w_z3 && w_z2 && w_z1;
    assign w_blank[0] = 1'b0;

    // Next anode/cathode pattern for the slot currently being scanned.
    always_comb begin
        w_digit_nxt   = 4'b1111;
        w_segment_nxt = 8'hFF;
        if (!w_blank[r_idx]) begin
            w_digit_nxt   = ~(4'b0001 << r_idx);
            w_segment_nxt = {~dp_en[r_idx], hex7(w_nib)};
        end
    end

    // Dwell counter and scan index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pending word; a new load outranks the clear caused by a commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 16'h0000;
            r_pend_v  <= 1'b0;
        end else begin
            if (load) begin
                r_pending <= data_in;
                r_pend_v  <= 1'b1;
            end else if (w_wrap) begin
                r_pend_v  <= 1'b0;
            end
        end
    end

    // Commit the pending word at the frame boundary (pre-edge pending value).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shown <= 16'h0000;
        end else if (w_wrap && r_pend_v) begin
            r_shown <= r_pending;
        end
    end

    // Registered display outputs and frame strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit   <= 4'b1111;
            r_segment <= 8'hFF;
            r_frame   <= 1'b0;
        end else begin
            r_digit   <= w_digit_nxt;
            r_segment <= w_segment_nxt;
            r_frame   <= w_wrap;
        end
    end

    assign digit   = r_digit;
    assign segment = r_segment;
    assign shown   = r_shown;
    assign frame   = r_frame;

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Multiplexed 4-digit seven-segment display driver that sits directly downstream of the CPU datapath. It consumes the 16-bit memory read word (port A) and shows it as four hex digits on the board's common-anode display. The CPU-side value is double-buffered and committed only at frame boundaries, so the display never shows a half-updated word. Refresh rate, leading-zero blanking and per-digit decimal points are controlled here.

## Interface

Parameters:
- REFRESH_DIV, default 50000: clock cycles each digit is driven (50 MHz gives 1 kHz per digit and 250 Hz per frame). Legal range is ≥ 2. The counter width is clog2(REFRESH_DIV).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  16  word to display; digit 3 = data_in[15:12] … digit 0 = data_in[3:0].
- load  input  1  one-cycle strobe; captures data_in into the pending register.
- blank_lz  input  1  1 = suppress leading zeros.
- dp_en  input  4  dp_en[i] = 1 lights the decimal point of digit i.
- digit  output  4  anode enables, active-low; digit[0] = rightmost.
- segment  output  8  active-low cathodes: {dp,g,f,e,d,c,b,a}.
- shown  output  16  currently committed display word.
- frame  output  1  one-cycle pulse on the edge where the scan index wraps 3→0.

## Operation

- **Pending register:** on any edge with load=1, pending ← data_in and pend_v ← 1. Back-to-back loads: the last one wins.
- **Refresh counter:** cnt counts 0..REFRESH_DIV-1. When cnt = REFRESH_DIV-1, cnt ← 0 and idx ← idx+1 (mod 4).
- **Commit:** on the edge where idx goes 3→0:
  - frame is 1 for that cycle.
  - If pend_v, then shown ← pending and pend_v ← 0.
  - A load sampled on that same edge is not committed; it appears after the next wrap.
  - If a load coincides with pend_v clearing, pend_v stays 1, because the set takes priority.
- **Decode (hex, active-low {g..a}):**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - segment[7] = ~dp_en[idx].
- **Blanking:**
  - With blank_lz=1, digit k (k = 3..1) is blank when shown[4k+3:4k] = 0 and all higher nibbles are 0.
  - Digit 0 is never blanked, so a value of 0 shows as a single "0".
  - A blank digit drives digit = 4'b1111 and segment = 8'hFF for its whole slot, and its dp is also suppressed.
- **Anode selection:** a non-blank slot drives digit = ~(4'b0001 << idx).

## Timing

- **Reset** (asynchronous, while reset=0), all immediate:
  - cnt = 0, idx = 0, shown = 16'h0000, pending = 0, pend_v = 0, frame = 0.
  - digit = 4'b1111, segment = 8'hFF.
  - Asserting reset mid-frame aborts the scan and discards any pending word.
- **Outputs** digit, segment and frame are registered:
  - They reflect idx and shown as they stood before the edge, giving one cycle of latency.
  - First edge after reset release: digit = 4'b1110, segment = 8'hC0 (digit 0 shows "0", dp off).
- **Dwell and frame:** each digit is driven for exactly REFRESH_DIV cycles. frame pulses once every 4·REFRESH_DIV cycles.
- **Load-to-display latency:** worst case 4·REFRESH_DIV+1 cycles, best case 2 cycles (load one edge before the wrap).
- **Input sampling:** dp_en and blank_lz are not latched and take effect on the next output update.

## Test plan

1. **Reset values:** REFRESH_DIV=4; hold reset=0 mid-run. Required: digit=1111 and segment=FF immediately. On release, the 1st edge gives digit=1110, segment=C0. digit steps 1110→1101→1011→0111 every 4 cycles, and frame pulses every 16 cycles.
2. **Commit timing:** load data_in=16'h12AF in the middle of a frame. Required: shown is unchanged until the wrap edge, then becomes 12AF. The next frame's segments are digit0=8E, digit1=88, digit2=A4, digit3=F9.
3. **Load coincident with wrap:** load=1 with data_in=16'h00FF on the same edge as frame. Required: shown stays at its old value for one more frame, then becomes 00FF.
4. **Leading-zero blanking:**
   - blank_lz=1, shown=16'h00F0: digits 3 and 2 give digit=1111/segment=FF in their slots; digit1 shows "F" (0E), digit0 shows "0" (C0).
   - shown=0: only digit0 lit.
   - blank_lz=0: all four digits lit.
5. **Decimal points:** dp_en=4'b0101 with shown=16'h8888. Required: segment=00 on digits 0 and 2, segment=80 on digits 1 and 3.
6. **Back-to-back loads and reset mid-pending:**
   - Loads of 1111, then 2222, then 3333 in consecutive cycles: only 3333 is committed.
   - A load followed by reset before the wrap: shown=0 after release and nothing is committed.
